// File: rtl/cache_axi_pkg.sv
// Shared types and helpers for the cache-line to word-AXI bridge.
// Read/write FSM encodings, word width, line alignment and the fixed byte-select.
package cache_axi_pkg;

  localparam int WORD_W = 32;
  localparam logic [3:0] AXI_SEL = 4'b1111;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_BUSY = 2'd1,
    R_DONE = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BUSY = 2'd1,
    W_DONE = 2'd2
  } w_state_e;

  // Clears the in-line byte offset; off_w is log2(line bytes).
  function automatic logic [WORD_W-1:0] line_base(input logic [WORD_W-1:0] addr,
                                                  input int off_w);
    line_base = addr & ~((32'd1 << off_w) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_axi_arbiter.sv
// Read-requester arbiter: fixed priority (lowest index) or round-robin from last_grant+1.
// Combinational grant, gated by gnt_en_i; last_grant updates only on an actual grant.
module cache_axi_arbiter #(
  parameter int N_RD   = 2,
  parameter int ARB_RR = 0,
  localparam int IDX_W = (N_RD > 1) ? $clog2(N_RD) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_RD-1:0]  elig_i,
  input  logic             gnt_en_i,
  output logic [N_RD-1:0]  gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [N_RD-1:0]  elig_shift;
  logic             found;
  int               cand;

  always_comb begin
    found      = 1'b0;
    gnt_idx_o  = '0;
    elig_shift = '0;
    cand       = 0;
    for (int i = 0; i < N_RD; i++) begin
      cand       = (ARB_RR != 0) ? ((int'(last_grant_q) + 1 + i) % N_RD) : i;
      elig_shift = elig_i >> cand;
      if (!found && elig_shift[0]) begin
        found     = 1'b1;
        gnt_idx_o = IDX_W'(cand);
      end
    end
    gnt_vld_o    = found && gnt_en_i;
    gnt_oh_o     = gnt_vld_o ? (N_RD'(1) << gnt_idx_o) : '0;
    last_grant_d = gnt_vld_o ? gnt_idx_o : last_grant_q;
  end

  // Reset to the top index so channel 0 is first in round-robin mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= IDX_W'(N_RD - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache-line bridge: N_RD arbitrated line readers plus one write-back, as single-word AXI beats.
// Read line done grant+1+LINE_WORDS at full rate; beats wait on rdata_valid_i / wdata_resp_i.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter int N_RD       = 2,
  parameter int LINE_WORDS = 8,
  parameter int ARB_RR     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_RD-1:0]              ren_i,
  input  logic [WORD_W*N_RD-1:0]       araddr_i,
  output logic [N_RD-1:0]              rvalid_o,
  output logic [WORD_W*LINE_WORDS-1:0] rdata_o,
  input  logic                         wen_i,
  input  logic [WORD_W-1:0]            awaddr_i,
  input  logic [WORD_W*LINE_WORDS-1:0] wdata_i,
  output logic                         bvalid_o,
  output logic                         axi_ce_o,
  output logic [3:0]                   axi_sel_o,
  output logic                         axi_ren_o,
  output logic                         axi_rready_o,
  output logic [WORD_W-1:0]            axi_raddr_o,
  input  logic [WORD_W-1:0]            rdata_i,
  input  logic                         rdata_valid_i,
  output logic                         axi_wen_o,
  output logic                         axi_wvalid_o,
  output logic [WORD_W-1:0]            axi_waddr_o,
  output logic [WORD_W-1:0]            axi_wdata_o,
  output logic                         axi_wlast_o,
  input  logic                         wdata_resp_i
);

  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  r_state_e           r_state_q, r_state_d;
  logic [WORD_W-1:0]  r_line_q, r_line_d;
  logic [IDX_W-1:0]   r_idx_q, r_idx_d;
  logic [CNT_W-1:0]   r_cnt_q, r_cnt_d;
  logic [LINE_W-1:0]  r_buf_q, r_buf_d;

  w_state_e           w_state_q, w_state_d;
  logic [WORD_W-1:0]  w_line_q, w_line_d;
  logic [CNT_W-1:0]   w_cnt_q, w_cnt_d;
  logic [LINE_W-1:0]  w_buf_q, w_buf_d;

  logic [N_RD-1:0]    elig;
  logic [N_RD-1:0]    gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic [WORD_W-1:0]  gnt_addr;
  logic [WORD_W-1:0]  ch_line;
  logic [WORD_W-1:0]  wr_line_in;
  logic               hazard;

  // A read may not start on a line that a write-back owns or is about to claim.
  always_comb begin
    elig       = '0;
    ch_line    = '0;
    hazard     = 1'b0;
    wr_line_in = line_base(awaddr_i, OFF_W);
    for (int k = 0; k < N_RD; k++) begin
      ch_line = line_base(araddr_i[WORD_W*k +: WORD_W], OFF_W);
      if (w_state_q != W_IDLE) begin
        hazard = (ch_line == w_line_q);
      end else begin
        hazard = wen_i && (ch_line == wr_line_in);
      end
      elig[k] = ren_i[k] && !hazard;
    end
  end

  cache_axi_arbiter #(
    .N_RD   (N_RD),
    .ARB_RR (ARB_RR)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .elig_i    (elig),
    .gnt_en_i  (r_state_q == R_IDLE),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    gnt_addr = '0;
    for (int k = 0; k < N_RD; k++) begin
      gnt_addr = gnt_addr | (araddr_i[WORD_W*k +: WORD_W] & {WORD_W{gnt_oh[k]}});
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_line_d  = r_line_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    r_buf_d   = r_buf_q;
    case (r_state_q)
      R_IDLE: begin
        if (gnt_vld) begin
          r_line_d  = line_base(gnt_addr, OFF_W);
          r_idx_d   = gnt_idx;
          r_cnt_d   = '0;
          r_state_d = R_BUSY;
        end
      end
      R_BUSY: begin
        if (rdata_valid_i) begin
          r_buf_d[WORD_W*int'(r_cnt_q) +: WORD_W] = rdata_i;
          if (r_cnt_q == LAST_BEAT) begin
            r_state_d = R_DONE;
          end else begin
            r_cnt_d = r_cnt_q + 1'b1;
          end
        end
      end
      R_DONE:  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_line_d  = w_line_q;
    w_cnt_d   = w_cnt_q;
    w_buf_d   = w_buf_q;
    case (w_state_q)
      W_IDLE: begin
        if (wen_i) begin
          w_line_d  = wr_line_in;
          w_buf_d   = wdata_i;
          w_cnt_d   = '0;
          w_state_d = W_BUSY;
        end
      end
      W_BUSY: begin
        if (wdata_resp_i) begin
          if (w_cnt_q == LAST_BEAT) begin
            w_state_d = W_DONE;
          end else begin
            w_cnt_d = w_cnt_q + 1'b1;
          end
        end
      end
      W_DONE:  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Every output is a pure decode of registered state, so reset clears them on the next edge.
  always_comb begin
    rvalid_o     = '0;
    rdata_o      = '0;
    bvalid_o     = 1'b0;
    axi_ren_o    = 1'b0;
    axi_rready_o = 1'b0;
    axi_raddr_o  = '0;
    axi_wen_o    = 1'b0;
    axi_wvalid_o = 1'b0;
    axi_waddr_o  = '0;
    axi_wdata_o  = '0;
    axi_wlast_o  = 1'b0;
    if (r_state_q == R_BUSY) begin
      axi_ren_o    = 1'b1;
      axi_rready_o = 1'b1;
      axi_raddr_o  = {r_line_q[WORD_W-1:OFF_W], r_cnt_q, 2'b00};
    end
    if (r_state_q == R_DONE) begin
      rvalid_o = N_RD'(1) << r_idx_q;
      rdata_o  = r_buf_q;
    end
    if (w_state_q == W_BUSY) begin
      axi_wen_o    = 1'b1;
      axi_wvalid_o = 1'b1;
      axi_waddr_o  = {w_line_q[WORD_W-1:OFF_W], w_cnt_q, 2'b00};
      axi_wdata_o  = w_buf_q[WORD_W*int'(w_cnt_q) +: WORD_W];
      axi_wlast_o  = (w_cnt_q == LAST_BEAT);
    end
    bvalid_o  = (w_state_q == W_DONE);
    axi_ce_o  = axi_ren_o | axi_wen_o;
    axi_sel_o = AXI_SEL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_line_q  <= '0;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      r_buf_q   <= '0;
      w_state_q <= W_IDLE;
      w_line_q  <= '0;
      w_cnt_q   <= '0;
      w_buf_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_line_q  <= r_line_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      r_buf_q   <= r_buf_d;
      w_state_q <= w_state_d;
      w_line_q  <= w_line_d;
      w_cnt_q   <= w_cnt_d;
      w_buf_q   <= w_buf_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed scoreboard bench: a fixed-priority 2-reader bridge plus a 3-reader round-robin bridge.
// Stimulus pushes expected beats/pulses; the negedge monitor also plays the AXI slave.
module tb_cache_axi_bridge;

  localparam int LW = 8;

  typedef struct {
    logic [1:0]   oh;
    logic [255:0] data;
    int           cyc;
  } rd_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Fixed-priority, N_RD=2 instance.
  logic [1:0]   ren_i;
  logic [63:0]  araddr_i;
  logic [1:0]   rvalid_o;
  logic [255:0] rdata_o;
  logic         wen_i;
  logic [31:0]  awaddr_i;
  logic [255:0] wdata_i;
  logic         bvalid_o, axi_ce_o, axi_ren_o, axi_rready_o;
  logic [3:0]   axi_sel_o;
  logic [31:0]  axi_raddr_o, rdata_i, axi_waddr_o, axi_wdata_o;
  logic         rdata_valid_i, axi_wen_o, axi_wvalid_o, axi_wlast_o, wdata_resp_i;

  // Round-robin, N_RD=3 instance.
  logic [2:0]   rr_ren;
  logic [95:0]  rr_araddr;
  logic [2:0]   rr_rvalid;
  logic [255:0] rr_rdata;
  logic         rr_bvalid, rr_ce, rr_axi_ren, rr_rready, rr_axi_wen, rr_wvalid, rr_wlast;
  logic [3:0]   rr_sel;
  logic [31:0]  rr_raddr, rr_rdata_in, rr_waddr, rr_wdata;
  logic         rr_rdata_valid;

  cache_axi_bridge #(.N_RD(2), .LINE_WORDS(LW), .ARB_RR(0)) dut (
    .clk(clk), .rst(rst), .ren_i(ren_i), .araddr_i(araddr_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .wen_i(wen_i), .awaddr_i(awaddr_i), .wdata_i(wdata_i),
    .bvalid_o(bvalid_o), .axi_ce_o(axi_ce_o), .axi_sel_o(axi_sel_o), .axi_ren_o(axi_ren_o),
    .axi_rready_o(axi_rready_o), .axi_raddr_o(axi_raddr_o), .rdata_i(rdata_i),
    .rdata_valid_i(rdata_valid_i), .axi_wen_o(axi_wen_o), .axi_wvalid_o(axi_wvalid_o),
    .axi_waddr_o(axi_waddr_o), .axi_wdata_o(axi_wdata_o), .axi_wlast_o(axi_wlast_o),
    .wdata_resp_i(wdata_resp_i)
  );

  cache_axi_bridge #(.N_RD(3), .LINE_WORDS(LW), .ARB_RR(1)) dut_rr (
    .clk(clk), .rst(rst), .ren_i(rr_ren), .araddr_i(rr_araddr), .rvalid_o(rr_rvalid),
    .rdata_o(rr_rdata), .wen_i(1'b0), .awaddr_i(32'h0), .wdata_i(256'h0),
    .bvalid_o(rr_bvalid), .axi_ce_o(rr_ce), .axi_sel_o(rr_sel), .axi_ren_o(rr_axi_ren),
    .axi_rready_o(rr_rready), .axi_raddr_o(rr_raddr), .rdata_i(rr_rdata_in),
    .rdata_valid_i(rr_rdata_valid), .axi_wen_o(rr_axi_wen), .axi_wvalid_o(rr_wvalid),
    .axi_waddr_o(rr_waddr), .axi_wdata_o(rr_wdata), .axi_wlast_o(rr_wlast),
    .wdata_resp_i(1'b0)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int rbeats = 0;
  int raw_base = 0;
  logic raw_chk  = 1'b0;
  logic rd_plain = 1'b0;

  rd_exp_t     rd_q[$];
  logic [31:0] ra_q[$];
  wb_exp_t     wb_q[$];
  int          b_q[$];
  logic [2:0]  rr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return rd_plain ? {29'd0, a[4:2]} : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic push_read(input int ch, input logic [31:0] addr, input int ecyc);
    rd_exp_t e;
    logic [31:0] base;
    base   = addr & ~32'h1F;
    e.oh   = 2'(1 << ch);
    e.data = '0;
    e.cyc  = ecyc;
    for (int i = 0; i < LW; i++) begin
      ra_q.push_back(base + 32'(4 * i));
      e.data[32*i +: 32] = rd_word(base + 32'(4 * i));
    end
    rd_q.push_back(e);
  endtask

  task automatic push_write(input logic [31:0] addr, input int ecyc);
    wb_exp_t e;
    logic [31:0] base;
    base = addr & ~32'h1F;
    for (int i = 0; i < LW; i++) begin
      e.addr = base + 32'(4 * i);
      e.data = 32'h8000_0000 + 32'(i);
      e.last = (i == LW - 1);
      wb_q.push_back(e);
    end
    b_q.push_back(ecyc);
  endtask

  // Requesters drop their level request in the cycle their done pulse appears.
  task automatic drain(input int budget, input string name);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (rvalid_o[0]) ren_i[0] = 1'b0;
      if (rvalid_o[1]) ren_i[1] = 1'b0;
      if (bvalid_o) wen_i = 1'b0;
      if (ren_i == 2'b00 && !wen_i) break;
    end
    if (n >= budget) begin
      fail_now(name);
      ren_i = 2'b00;
      wen_i = 1'b0;
    end
  endtask

  // AXI slave responder plus scoreboard monitor.
  always @(negedge clk) begin
    rdata_valid_i  = axi_ren_o && rst;
    rdata_i        = rdata_valid_i ? rd_word(axi_raddr_o) : 32'h0;
    wdata_resp_i   = axi_wen_o && rst;
    rr_rdata_valid = rr_axi_ren;
    rr_rdata_in    = rr_raddr;
    if (rdata_valid_i) begin
      rbeats++;
      if (ra_q.size() == 0) fail_now("unexpected_rd_beat");
      else begin
        chk("rd_beat_addr", 256'(axi_raddr_o), 256'(ra_q.pop_front()));
        chk("rd_beat_ctl", 256'({axi_rready_o, axi_ce_o}), 256'(2'b11));
      end
    end
    if (wdata_resp_i) begin
      if (wb_q.size() == 0) fail_now("unexpected_wr_beat");
      else begin
        wb_exp_t w;
        w = wb_q.pop_front();
        chk("wr_beat_addr", 256'(axi_waddr_o), 256'(w.addr));
        chk("wr_beat_data", 256'(axi_wdata_o), 256'(w.data));
        chk("wr_beat_last", 256'(axi_wlast_o), 256'(w.last));
        chk("wr_beat_ctl", 256'({axi_wvalid_o, axi_ce_o}), 256'(2'b11));
      end
    end
    if (rvalid_o != 2'b00) begin
      if (rd_q.size() == 0) fail_now("unexpected_rvalid");
      else begin
        rd_exp_t r;
        r = rd_q.pop_front();
        chk("rvalid_oh", 256'(rvalid_o), 256'(r.oh));
        chk("rdata_line", rdata_o, r.data);
        if (r.cyc >= 0) chk("rvalid_cycle", 256'(cyc), 256'(r.cyc));
      end
    end
    if (bvalid_o) begin
      if (b_q.size() == 0) fail_now("unexpected_bvalid");
      else chk("bvalid_cycle", 256'(cyc), 256'(b_q.pop_front()));
      if (raw_chk) chk("raw_beats_before_bvalid", 256'(rbeats - raw_base), 256'(0));
    end
    if (rr_rvalid != 3'b000) begin
      if (rr_q.size() == 0) fail_now("unexpected_rr_rvalid");
      else chk("rr_grant", 256'(rr_rvalid), 256'(rr_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    rst = 1'b0;
    ren_i = 2'b00; araddr_i = '0; wen_i = 1'b0; awaddr_i = '0; wdata_i = '0;
    rr_ren = 3'b000; rr_araddr = '0;
    for (int i = 0; i < LW; i++) wdata_i[32*i +: 32] = 32'h8000_0000 + 32'(i);
    repeat (3) @(negedge clk);
    chk("rst_rvalid", 256'(rvalid_o), 256'(0));
    chk("rst_bvalid", 256'(bvalid_o), 256'(0));
    chk("rst_axi_rd", 256'({axi_ce_o, axi_ren_o, axi_rready_o, axi_raddr_o}), 256'(0));
    chk("rst_axi_wr", 256'({axi_wen_o, axi_wvalid_o, axi_wlast_o, axi_waddr_o, axi_wdata_o}), 256'(0));
    chk("rst_sel", 256'(axi_sel_o), 256'(4'hF));
    chk("rst_rr_rvalid", 256'(rr_rvalid), 256'(0));
    rst = 1'b1;

    // Round-robin: all three request continuously, expect 0,1,2,0.
    @(negedge clk);
    rr_araddr = {32'h0000_3300, 32'h0000_2200, 32'h0000_1100};
    rr_q.push_back(3'b001); rr_q.push_back(3'b010);
    rr_q.push_back(3'b100); rr_q.push_back(3'b001);
    rr_ren = 3'b111;
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clk);
      if (rr_rvalid != 3'b000) n++;
    end
    rr_ren = 3'b000;
    if (n < 4) fail_now("rr_timeout");

    // Single read on channel 1, words 0..7, latency grant+1+8.
    @(negedge clk);
    rd_plain = 1'b1;
    c = cyc;
    push_read(1, 32'h006C_46A8, c + 9);
    rd_q[rd_q.size()-1].data = '0;
    for (int i = 0; i < LW; i++) rd_q[rd_q.size()-1].data[32*i +: 32] = 32'(i);
    araddr_i = {32'h006C_46A8, 32'h0};
    ren_i = 2'b10;
    drain(40, "single_read_timeout");
    rd_plain = 1'b0;

    // Fixed priority: simultaneous requests, channel 0 first.
    @(negedge clk);
    c = cyc;
    push_read(0, 32'h0000_1004, c + 9);
    push_read(1, 32'h0000_8010, c + 19);
    araddr_i = {32'h0000_8010, 32'h0000_1004};
    ren_i = 2'b11;
    drain(60, "priority_timeout");

    // ICache transfer in flight is not pre-empted by DCache.
    @(negedge clk);
    c = cyc;
    push_read(1, 32'h0000_A0E0, c + 9);
    push_read(0, 32'h0000_B000, c + 19);
    araddr_i = {32'h0000_A0E0, 32'h0000_B000};
    ren_i = 2'b10;
    for (n = 0; n < 10 && !axi_ren_o; n++) @(negedge clk);
    if (!axi_ren_o) fail_now("icache_start_timeout");
    ren_i[0] = 1'b1;
    drain(60, "no_preempt_timeout");

    // Concurrent read and write to different lines, both done on the same cycle.
    @(negedge clk);
    c = cyc;
    push_read(0, 32'h0000_2044, c + 9);
    push_write(32'h8000_1000, c + 9);
    araddr_i = {32'h0, 32'h0000_2044};
    awaddr_i = 32'h8000_1000;
    ren_i = 2'b01;
    wen_i = 1'b1;
    drain(40, "concurrent_timeout");

    // RAW hazard: read of the same line waits until the write-back completes.
    @(negedge clk);
    c = cyc;
    push_write(32'h0000_300C, c + 9);
    push_read(1, 32'h0000_3018, c + 19);
    raw_base = rbeats;
    raw_chk = 1'b1;
    araddr_i = {32'h0000_3018, 32'h0};
    awaddr_i = 32'h0000_300C;
    ren_i = 2'b10;
    wen_i = 1'b1;
    drain(60, "raw_timeout");
    raw_chk = 1'b0;

    // Reset during beat 3 of a read.
    @(negedge clk);
    push_read(1, 32'h0000_4070, -1);
    araddr_i = {32'h0000_4070, 32'h0};
    ren_i = 2'b10;
    for (n = 0; n < 20 && !(axi_ren_o && axi_raddr_o == 32'h0000_406C); n++) @(negedge clk);
    if (n >= 20) fail_now("beat3_timeout");
    rst = 1'b0;
    ren_i = 2'b00;
    @(negedge clk);
    ra_q.delete();
    rd_q.delete();
    chk("midrst_rvalid", 256'({rvalid_o, bvalid_o}), 256'(0));
    chk("midrst_rdata", rdata_o, 256'(0));
    chk("midrst_axi_rd", 256'({axi_ce_o, axi_ren_o, axi_rready_o, axi_raddr_o}), 256'(0));
    chk("midrst_axi_wr", 256'({axi_wen_o, axi_wvalid_o, axi_wlast_o, axi_waddr_o, axi_wdata_o}), 256'(0));
    chk("midrst_sel", 256'(axi_sel_o), 256'(4'hF));
    rst = 1'b1;
    @(negedge clk);
    c = cyc;
    push_read(0, 32'h0000_5000, c + 9);
    araddr_i = {32'h0, 32'h0000_5000};
    ren_i = 2'b01;
    drain(40, "post_reset_timeout");

    repeat (5) @(negedge clk);
    chk("rd_q_empty", 256'(rd_q.size()), 256'(0));
    chk("ra_q_empty", 256'(ra_q.size()), 256'(0));
    chk("wb_q_empty", 256'(wb_q.size()), 256'(0));
    chk("b_q_empty", 256'(b_q.size()), 256'(0));
    chk("rr_q_empty", 256'(rr_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Parametrised successor of the cache-to-AXI interface. It serves `N_RD` cache read-line requesters (channel 0 = DCache, channel 1 = ICache, further channels for prefetch or uncached masters) and one DCache write-back channel, each transferring one `LINE_WORDS`-word cache line as single-word beats on the word-level AXI adapter. Reads and writes run concurrently on independent FSMs. The read arbiter is selectable between fixed priority and round-robin. A same-line read-after-write hazard interlock is added.

## Interface

**Parameters**
- `N_RD`, default 2: number of read requesters, 1..8.
- `LINE_WORDS`, default 8: 32-bit words per line; a power of two, 2..16. `OFF_W = log2(LINE_WORDS)+2`.
- `ARB_RR`, default 0: read arbitration mode. 0 = fixed priority (lowest index wins); 1 = round-robin.

**Ports**
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-low.
- `ren_i`  in  `N_RD`  per-channel read-line request, level.
- `araddr_i`  in  `32*N_RD`  per-channel byte address; channel k is at `[32k+31:32k]`.
- `rvalid_o`  out  `N_RD`  one-cycle line-ready pulse to the granted channel.
- `rdata_o`  out  `32*LINE_WORDS`  shared line bus; word i is at `[32i+31:32i]`. Meaningful only while a `rvalid_o` bit is high.
- `wen_i`  in  1  write-back request, level.
- `awaddr_i`  in  32  write-back byte address.
- `wdata_i`  in  `32*LINE_WORDS`  line to write.
- `bvalid_o`  out  1  one-cycle write-done pulse.
- `axi_ce_o`  out  1  equals `axi_ren_o | axi_wen_o`.
- `axi_sel_o`  out  4  constant `4'b1111`.
- `axi_ren_o`, `axi_rready_o`  out  1  read beat request and ready.
- `axi_raddr_o`  out  32  read beat address.
- `rdata_i`  in  32  returned word.
- `rdata_valid_i`  in  1  returned word valid, one cycle per beat.
- `axi_wen_o`, `axi_wvalid_o`  out  1  write beat request and data valid.
- `axi_waddr_o`, `axi_wdata_o`  out  32  write beat address and data.
- `axi_wlast_o`  out  1  high during the final beat.
- `wdata_resp_i`  in  1  per-beat write acknowledge.

## Operation

**Read FSM: R_IDLE → R_BUSY → R_DONE → R_IDLE**
- **R_IDLE.** Eligible channels are those with `ren_i[k]=1` that are not blocked by the hazard interlock. If any channel is eligible:
  - grant one;
  - latch its line base `araddr & ~(2^OFF_W-1)` and the grant index;
  - clear the beat counter;
  - go to R_BUSY.
- **R_BUSY.**
  - Outputs: `axi_ren_o = axi_rready_o = 1`; `axi_raddr_o = {line, cnt, 2'b00}`.
  - On `rdata_valid_i`, store `rdata_i` into buffer word `cnt`.
  - If `cnt == LINE_WORDS-1`, go to R_DONE; otherwise increment `cnt`.
- **R_DONE.** Assert `rvalid_o[grant]` for exactly one cycle with `rdata_o = buffer`, then return to R_IDLE.
- A granted transfer is never pre-empted. Requests raised mid-transfer wait their turn.
- Requesters must drop `ren_i` in the cycle they see `rvalid_o`. A request still high in the following R_IDLE cycle is treated as a new request.

**Arbitration**
- `ARB_RR=0`: the lowest eligible index wins. DCache beats ICache.
- `ARB_RR=1`: the search starts at `last_grant+1` modulo `N_RD`. `last_grant` updates on every grant.

**Write FSM: W_IDLE → W_BUSY → W_DONE → W_IDLE**
- Independent of the read FSM.
- **W_IDLE.** On `wen_i`, latch the line base and `wdata_i`, clear the beat counter, and go to W_BUSY.
- **W_BUSY.**
  - Outputs: `axi_wen_o = axi_wvalid_o = 1`; `axi_waddr_o = {line, cnt, 2'b00}`; `axi_wdata_o` = latched word `cnt`; `axi_wlast_o = (cnt == LINE_WORDS-1)`.
  - `wdata_resp_i` advances `cnt`. On the last beat, go to W_DONE.
- **W_DONE.** Assert `bvalid_o` for one cycle, then return to W_IDLE.

**Hazard interlock**
- In R_IDLE, channel k is ineligible if its line base equals:
  - the latched write line while the write FSM is not in W_IDLE; or
  - `awaddr_i`'s line base while the write FSM is in W_IDLE and `wen_i=1`.
- Other channels may still be granted in the same cycle.

## Timing

- **Reset.** `rst=0` at any clock edge, including mid-burst:
  - both FSMs go to IDLE;
  - all outputs are 0 except `axi_sel_o`;
  - `last_grant = N_RD-1`, so channel 0 is favoured first in round-robin mode;
  - the AXI side must abandon any partial burst.
- **Read latency.** Grant in cycle t. `axi_ren_o` goes high at t+1. With a beat returned every cycle, `rvalid_o` pulses at t+1+`LINE_WORDS`.
- **Beat address.** `axi_raddr_o` and `axi_waddr_o` change only on the edge following an acknowledge.
- **Simultaneous events.** A read grant and a write acceptance may occur in the same cycle. `rvalid_o` and `bvalid_o` may pulse together.
- **Ignored inputs.** `rdata_valid_i` outside R_BUSY and `wdata_resp_i` outside W_BUSY are ignored.

## Structure

- **Package `cache_axi_pkg`:**
  - read and write state encodings;
  - `WORD_W = 32`;
  - the `line_base()` function;
  - the `axi_sel_o` constant.
- **Sub-module `cache_axi_arbiter`.** Parametrised by `N_RD` and `ARB_RR`. Inputs: eligible vector, grant-enable. Outputs: one-hot grant and encoded index. It owns the `last_grant` register.

## Test plan

- **Single read.** Channel 1 reads `0x006C46A8`, returning words 0..7 in consecutive cycles. Check beat addresses `0x006C46A0`…`0x006C46BC`, `rvalid_o=2'b10` for one cycle, and `rdata_o = 0x00000007_…_00000000`.
- **Fixed priority.** `ARB_RR=0`, channels 0 and 1 request in the same cycle. Channel 0's line completes first, then channel 1's. An ICache transfer already in progress is not interrupted by a later DCache request.
- **Round-robin.** `ARB_RR=1`, `N_RD=3`, all channels requesting continuously. Grant order is 0, 1, 2, 0.
- **Concurrent read and write.** A write of `0x80000007…80000000` and a read of a different line start together. Beats interleave, `axi_wlast_o` is high only on beat 7, and both done pulses occur.
- **RAW hazard.** A write and a read to the same line are raised in the same cycle. No read beat is issued until after `bvalid_o`, and the read then returns.
- **Reset mid-burst.** `rst=0` during beat 3. All outputs are 0 on the next cycle, and a fresh request afterwards completes correctly.
